// File: rtl/arduino_bridge_pkg.sv
// Shared constants for the Arduino bridge: register map, STATUS bit
// positions and the output handshake state encoding.
package arduino_bridge_pkg;

  localparam logic [1:0] ADDR_DATA_IN  = 2'd0;
  localparam logic [1:0] ADDR_DATA_OUT = 2'd1;
  localparam logic [1:0] ADDR_STATUS   = 2'd2;
  localparam logic [1:0] ADDR_CTRL     = 2'd3;

  localparam int STAT_CHANGED = 0;
  localparam int STAT_BUSY    = 1;
  localparam int STAT_OVERRUN = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STROBE  = 2'd1,
    ST_RELEASE = 2'd2
  } out_state_t;

endpackage

// File: rtl/arduino_sync.sv
// Two-flop synchronizer for asynchronous Arduino-side signals.
module arduino_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] async_in,
  output logic [W-1:0] sync_out
);

  logic [W-1:0] meta;

  // First flop may go metastable; second flop gives it a full cycle to settle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= '0;
      sync_out <= '0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/arduino_bridge.sv
// Processor-to-Arduino bridge: debounced input port, handshaked output
// port, sticky status and an optional interrupt.
// Optional feature: define ARDUINO_BRIDGE_IRQ_EN to get a writable CTRL
// irq_en bit and a live irq output; otherwise irq is 0 and CTRL reads 0.
module arduino_bridge
  import arduino_bridge_pkg::*;
#(
  parameter int IN_W       = 8,
  parameter int OUT_W      = 8,
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             re,
  input  logic [1:0]       addr,
  input  logic [31:0]      module_input,
  output logic [31:0]      module_output,
  input  logic [IN_W-1:0]  system_input,
  output logic [OUT_W-1:0] system_output,
  output logic             out_strobe,
  input  logic             out_ack,
  output logic             irq
);

  localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

  logic [IN_W-1:0] in_sync;
  logic [IN_W-1:0] in_prev;
  logic [IN_W-1:0] deb_reg;
  logic [15:0]     deb_cnt;
  logic [15:0]     cnt_next;
  logic            in_diff;
  logic            deb_load;
  logic            changed_set;
  logic            ack_sync;
  logic            changed;
  logic            overrun;
  logic            busy;
  logic            wr_out;
  logic            stat_rd;
  logic            overrun_set;
  logic            irq_en;
  logic [31:0]     rd_next;
  logic            unused_wdata;
  out_state_t      state;

  arduino_sync #(.W(IN_W)) u_sync_in (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (system_input),
    .sync_out (in_sync)
  );

  arduino_sync #(.W(1)) u_sync_ack (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (out_ack),
    .sync_out (ack_sync)
  );

  // Upper write-data bits are only meaningful for some registers
  assign unused_wdata = ^module_input;

  assign busy        = (state != ST_IDLE);
  assign wr_out      = we && (addr == ADDR_DATA_OUT);
  assign stat_rd     = re && (addr == ADDR_STATUS);
  assign overrun_set = wr_out && busy;

  // Count consecutive stable cycles; load once the count hits its last value
  always_comb begin
    in_diff     = (in_sync != in_prev);
    cnt_next    = '0;
    if (!in_diff) begin
      cnt_next = (deb_cnt == DEB_LAST) ? deb_cnt : deb_cnt + 16'd1;
    end
    deb_load    = !in_diff && (cnt_next == DEB_LAST);
    changed_set = deb_load && (in_sync != deb_reg);
  end

  // Debounce state: previous sample, stability counter, accepted value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_prev <= '0;
      deb_cnt <= '0;
      deb_reg <= '0;
    end else begin
      in_prev <= in_sync;
      deb_cnt <= cnt_next;
      if (deb_load) begin
        deb_reg <= in_sync;
      end
    end
  end

  // Sticky status bits; a set in the same cycle as a STATUS read wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (changed_set) begin
        changed <= 1'b1;
      end else if (stat_rd) begin
        changed <= 1'b0;
      end
      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (stat_rd) begin
        overrun <= 1'b0;
      end
    end
  end

  // Output handshake: strobe until ack rises, then wait for ack to fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      system_output <= '0;
      out_strobe    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_out) begin
            system_output <= module_input[OUT_W-1:0];
            out_strobe    <= 1'b1;
            state         <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (ack_sync) begin
            out_strobe <= 1'b0;
            state      <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!ack_sync) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          out_strobe <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ARDUINO_BRIDGE_IRQ_EN
  // CTRL bit0 enables the interrupt; irq is a registered level of changed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (we && (addr == ADDR_CTRL)) begin
        irq_en <= module_input[0];
      end
      irq <= changed && irq_en;
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  // Select the addressed register, zero-extended
  always_comb begin
    rd_next = '0;
    case (addr)
      ADDR_DATA_IN:  rd_next[IN_W-1:0]  = deb_reg;
      ADDR_DATA_OUT: rd_next[OUT_W-1:0] = system_output;
      ADDR_STATUS: begin
        rd_next[STAT_CHANGED] = changed;
        rd_next[STAT_BUSY]    = busy;
        rd_next[STAT_OVERRUN] = overrun;
      end
      default:       rd_next[0] = irq_en;
    endcase
  end

  // Registered read data, refreshed every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      module_output <= '0;
    end else begin
      module_output <= rd_next;
    end
  end

endmodule

// File: tb/tb_arduino_bridge.sv
// Directed testbench for arduino_bridge: register table plus hand-built
// sequences for debounce, bounce rejection, handshake timing, irq and reset.
module tb_arduino_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] module_input = '0;
  logic [31:0] module_output;
  logic [7:0]  system_input = '0;
  logic [7:0]  system_output;
  logic        out_strobe;
  logic        out_ack = 1'b0;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

`ifdef ARDUINO_BRIDGE_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic        re;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [7:0]  exp_sys;
    logic        exp_strobe;
  } vec_t;

  vec_t tbl[12];

  arduino_bridge #(.IN_W(8), .OUT_W(8), .DEB_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .we            (we),
    .re            (re),
    .addr          (addr),
    .module_input  (module_input),
    .module_output (module_output),
    .system_input  (system_input),
    .system_output (system_output),
    .out_strobe    (out_strobe),
    .out_ack       (out_ack),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expectation
  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and land just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one processor access and clock it in
  task automatic apply_stimulus(input logic w, input logic r, input logic [1:0] a, input logic [31:0] d);
    we = w;
    re = r;
    addr = a;
    module_input = d;
    tick();
  endtask

  // Hold reset for two cycles, check cleared outputs, release on a falling edge
  task automatic do_reset();
    rst_n = 1'b0;
    we = 1'b0;
    re = 1'b0;
    addr = 2'd0;
    module_input = '0;
    system_input = '0;
    out_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset module_output", module_output, 32'h0);
    check_output("reset system_output", {24'h0, system_output}, 32'h0);
    check_output("reset out_strobe", {31'h0, out_strobe}, 32'h0);
    check_output("reset irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    // we, re, addr, wdata, expected read, expected system_output, expected strobe
    tbl[0]  = '{1'b0, 1'b0, 2'd0, 32'h0,        32'h0,  8'h00, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 2'd2, 32'h0,        32'h0,  8'h00, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 2'd3, 32'h0,        32'h0,  8'h00, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 2'd0, 32'hFF,       32'h0,  8'h00, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 2'd2, 32'hFF,       32'h0,  8'h00, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 2'd2, 32'h0,        32'h0,  8'h00, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 2'd1, 32'hABCD_003C, 32'h0, 8'h3C, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 2'd1, 32'h0,        32'h3C, 8'h3C, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 2'd2, 32'h0,        32'h2,  8'h3C, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 2'd1, 32'h55,       32'h3C, 8'h3C, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 2'd2, 32'h0,        32'h6,  8'h3C, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 2'd2, 32'h0,        32'h2,  8'h3C, 1'b1};

    do_reset();

    // Register map, write filtering, DATA_OUT load and overrun
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata);
      check_output($sformatf("vec%0d module_output", i), module_output, tbl[i].exp_rd);
      check_output($sformatf("vec%0d system_output", i), {24'h0, system_output}, {24'h0, tbl[i].exp_sys});
      check_output($sformatf("vec%0d out_strobe", i), {31'h0, out_strobe}, {31'h0, tbl[i].exp_strobe});
    end

    // Ack rises: strobe drops on the third edge
    we = 1'b0; re = 1'b1; addr = 2'd2;
    out_ack = 1'b1;
    tick();
    tick();
    check_output("strobe held 2 cycles after ack", {31'h0, out_strobe}, 32'h1);
    tick();
    check_output("strobe dropped 3 cycles after ack", {31'h0, out_strobe}, 32'h0);
    // Ack falls: FSM returns to IDLE on the third edge, seen one read later
    out_ack = 1'b0;
    tick();
    tick();
    tick();
    check_output("busy still set at ack fall+3 read", module_output, 32'h2);
    tick();
    check_output("busy cleared after release", module_output, 32'h0);
    apply_stimulus(1'b0, 1'b0, 2'd1, 32'h0);
    check_output("DATA_OUT readback after handshake", module_output, 32'h3C);

    // Reset during STROBE aborts immediately
    apply_stimulus(1'b1, 1'b0, 2'd1, 32'h3C);
    we = 1'b0;
    check_output("strobe before mid reset", {31'h0, out_strobe}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("mid reset out_strobe", {31'h0, out_strobe}, 32'h0);
    check_output("mid reset system_output", {24'h0, system_output}, 32'h0);
    check_output("mid reset module_output", module_output, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    apply_stimulus(1'b0, 1'b0, 2'd2, 32'h0);
    check_output("busy clear after mid reset", module_output, 32'h0);

    // Debounced input change with optional interrupt
    do_reset();
    apply_stimulus(1'b1, 1'b0, 2'd3, 32'h1);
    apply_stimulus(1'b0, 1'b0, 2'd3, 32'h0);
    check_output("CTRL readback", module_output, {31'h0, IRQ_ON});
    addr = 2'd0;
    system_input = 8'hA5;
    repeat (6) tick();
    check_output("DATA_IN before debounce done", module_output, 32'h0);
    tick();
    check_output("DATA_IN after debounce", module_output, 32'hA5);
    check_output("irq after change", {31'h0, irq}, {31'h0, IRQ_ON});
    apply_stimulus(1'b0, 1'b1, 2'd2, 32'h0);
    check_output("STATUS changed set", module_output, 32'h1);
    check_output("irq held until clear", {31'h0, irq}, {31'h0, IRQ_ON});
    apply_stimulus(1'b0, 1'b1, 2'd2, 32'h0);
    check_output("STATUS after read clear", module_output, 32'h0);
    check_output("irq after clear", {31'h0, irq}, 32'h0);
    re = 1'b0;

    // Input bouncing every 2 cycles is never accepted
    do_reset();
    addr = 2'd0;
    for (int i = 0; i < 40; i++) begin
      system_input = (((i / 2) % 2) == 0) ? 8'hFF : 8'h00;
      tick();
      check_output($sformatf("bounce DATA_IN cycle %0d", i), module_output, 32'h0);
    end
    repeat (10) tick();
    apply_stimulus(1'b0, 1'b1, 2'd2, 32'h0);
    check_output("bounce STATUS", module_output, 32'h0);
    check_output("bounce irq", {31'h0, irq}, 32'h0);
    re = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
